dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 95 +++++++++
 tb/tb_dmem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin or fixed-priority grant,
// one registered access per cycle, response two cycles after grant.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   req*/addr*/wdata*/we*      requester side (two ports)
//   gnt*                       combinational accept
//   rvalid*, rdata             one-cycle response pulse and data
//   daddr/dwdata/dwe, drdata   shared dmem port
module dmem_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  we0,
  input  logic [3:0]  we1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]  state;
  logic        last;
  logic        id_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  we_q;
  logic        pick0;

  // last=1 means port 1 won most recently, so port 0 wins a tie.
  always_comb begin
    pick0 = 1'b0;
    if (FIXED_PRIO != 0) begin
      pick0 = req0;
    end else begin
      pick0 = req0 & (~req1 | last);
    end
  end

  // Grants are masked by reset so they drop the moment it asserts.
  assign gnt0 = ~reset & pick0;
  assign gnt1 = ~reset & req1 & ~pick0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last    <= 1'b1;
      id_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
    end else begin
      if (gnt0 | gnt1) begin
        state   <= ACCESS;
        id_q    <= gnt1;
        last    <= gnt1;
        addr_q  <= gnt1 ? addr1 : addr0;
        wdata_q <= gnt1 ? wdata1 : wdata0;
        we_q    <= gnt1 ? we1 : we0;
      end else begin
        state <= IDLE;
      end
      // drdata is sampled before the write lands: pre-write contents.
      rvalid0 <= (state == ACCESS) & ~id_q;
      rvalid1 <= (state == ACCESS) & id_q;
      if (state == ACCESS) begin
        rdata <= drdata;
      end
    end
  end

  // Address/data hold their last values in IDLE; only dwe is gated.
  assign daddr  = addr_q;
  assign dwdata = wdata_q;
  assign dwe    = (state == ACCESS) ? we_q : 4'b0000;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin and fixed-priority instances
// checked against a cycle-level transaction model plus directed vectors.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  we0, we1;

  logic [1:0]  g0, g1, rv0, rv1;
  logic [31:0] rd [2];
  logic [31:0] da [2];
  logic [31:0] dw [2];
  logic [3:0]  de [2];
  logic [31:0] dr [2];

  logic [31:0] mem [2][64];
  logic        tb_init;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .gnt0(g0[0]), .gnt1(g1[0]),
    .rvalid0(rv0[0]), .rvalid1(rv1[0]),
    .rdata(rd[0]), .daddr(da[0]),
    .dwdata(dw[0]), .dwe(de[0]),
    .drdata(dr[0])
  );

  dmem_arbiter #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .gnt0(g0[1]), .gnt1(g1[1]),
    .rvalid0(rv0[1]), .rvalid1(rv1[1]),
    .rdata(rd[1]), .daddr(da[1]),
    .dwdata(dw[1]), .dwe(de[1]),
    .drdata(dr[1])
  );

  function automatic logic [31:0] init_val(int k, int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 2) return 32'h11223344;
    return (32'h9E3779B9 * (i + 1)) ^ k;
  endfunction

  assign dr[0] = mem[0][da[0][7:2]];
  assign dr[1] = mem[1][da[1][7:2]];

  // Memory written only here: preload, then byte-lane writes.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (tb_init) begin
        for (int i = 0; i < 64; i++) mem[k][i] <= init_val(k, i);
      end else begin
        for (int b = 0; b < 4; b++)
          if (de[k][b])
            mem[k][da[k][7:2]][8*b +: 8] <= dw[k][8*b +: 8];
      end
    end
  end

  // Transaction-level reference model, one per instance.
  int          m_last [2];
  int          eg     [2];
  bit          acc_v  [2];
  int          acc_id [2];
  logic [31:0] acc_a  [2];
  logic [31:0] acc_w  [2];
  logic [3:0]  acc_we [2];
  bit          rsp_v  [2];
  int          rsp_id [2];
  logic [31:0] rsp_d  [2];
  logic [31:0] da_l   [2];
  logic [31:0] dw_l   [2];
  logic [31:0] ref_mem [2][64];

  logic [1:0]  gh  [2];
  logic [1:0]  rvh [2];
  logic [31:0] rdh [2];
  logic [31:0] dah [2];
  logic [3:0]  deh [2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_check(int k);
    string s;
    logic [31:0] e_da, e_dw;
    logic [3:0]  e_de;
    s = $sformatf("[%0d]", k);
    eg[k] = -1;
    if (!reset) begin
      if (req0 && req1)
        eg[k] = (k == 1) ? 0 : (m_last[k] == 0 ? 1 : 0);
      else if (req0)
        eg[k] = 0;
      else if (req1)
        eg[k] = 1;
    end
    gh[k]  = {g1[k], g0[k]};
    rvh[k] = {rv1[k], rv0[k]};
    rdh[k] = rd[k];
    dah[k] = da[k];
    deh[k] = de[k];
    chk({"gnt0", s}, 32'(g0[k]), 32'(eg[k] == 0));
    chk({"gnt1", s}, 32'(g1[k]), 32'(eg[k] == 1));
    if (reset) begin
      chk({"rst_dwe", s}, 32'(de[k]), 0);
      chk({"rst_daddr", s}, da[k], 0);
      chk({"rst_dwdata", s}, dw[k], 0);
      chk({"rst_rdata", s}, rd[k], 0);
      chk({"rst_rv", s}, 32'({rv1[k], rv0[k]}), 0);
    end else begin
      e_de = acc_v[k] ? acc_we[k] : 4'b0;
      e_da = acc_v[k] ? acc_a[k] : da_l[k];
      e_dw = acc_v[k] ? acc_w[k] : dw_l[k];
      chk({"dwe", s}, 32'(de[k]), 32'(e_de));
      chk({"daddr", s}, da[k], e_da);
      chk({"dwdata", s}, dw[k], e_dw);
      chk({"rvalid0", s}, 32'(rv0[k]),
          32'(rsp_v[k] && rsp_id[k] == 0));
      chk({"rvalid1", s}, 32'(rv1[k]),
          32'(rsp_v[k] && rsp_id[k] == 1));
      if (rsp_v[k]) chk({"rdata", s}, rd[k], rsp_d[k]);
    end
  endtask

  task automatic model_update(int k);
    int idx;
    if (reset) begin
      m_last[k] = 1;
      acc_v[k]  = 0;
      rsp_v[k]  = 0;
      da_l[k]   = '0;
      dw_l[k]   = '0;
      return;
    end
    rsp_v[k] = acc_v[k];
    if (acc_v[k]) begin
      idx = int'(acc_a[k][7:2]);
      rsp_id[k] = acc_id[k];
      rsp_d[k]  = ref_mem[k][idx];
      for (int b = 0; b < 4; b++)
        if (acc_we[k][b])
          ref_mem[k][idx][8*b +: 8] = acc_w[k][8*b +: 8];
      da_l[k] = acc_a[k];
      dw_l[k] = acc_w[k];
    end
    acc_v[k] = (eg[k] >= 0);
    if (eg[k] >= 0) begin
      acc_id[k] = eg[k];
      acc_a[k]  = eg[k] == 1 ? addr1 : addr0;
      acc_w[k]  = eg[k] == 1 ? wdata1 : wdata0;
      acc_we[k] = eg[k] == 1 ? we1 : we0;
      m_last[k] = eg[k];
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check(0);
    model_check(1);
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
  endtask

  task automatic reset_cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int busy;
    reset = 1'b1;
    tb_init = 1'b1;
    {req0, req1} = 2'b00;
    addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0;
    we0 = '0; we1 = '0;
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 1; acc_v[k] = 0; rsp_v[k] = 0;
      da_l[k] = '0; dw_l[k] = '0; eg[k] = -1;
      for (int i = 0; i < 64; i++) ref_mem[k][i] = init_val(k, i);
    end
    @(posedge clk);
    #1;
    tb_init = 1'b0;

    // Request held during reset must not be granted.
    req0 = 1'b1;
    cycle();
    chk("gnt_in_reset", 32'(gh[0]), 0);
    reset = 1'b0;

    // Single read; first req after reset is granted at once.
    addr0 = 32'h10; we0 = 4'b0000;
    cycle();
    chk("rd_gnt", 32'(gh[0]), 32'b01);
    req0 = 1'b0;
    cycle();
    chk("rd_daddr", dah[0], 32'h10);
    chk("rd_dwe", 32'(deh[0]), 0);
    cycle();
    chk("rd_rvalid", 32'(rvh[0]), 32'b01);
    chk("rd_rdata", rdh[0], 32'hDEADBEEF);

    // Byte write on port 1.
    req1 = 1'b1; addr1 = 32'h8;
    wdata1 = 32'h000000AA; we1 = 4'b0001;
    cycle();
    req1 = 1'b0;
    cycle();
    chk("wr_dwe", 32'(deh[0]), 32'b0001);
    cycle();
    chk("wr_rvalid", 32'(rvh[0]), 32'b10);
    chk("wr_rdata", rdh[0], 32'h11223344);
    chk("wr_mem", mem[0][2], 32'h112233AA);

    // Round-robin contention for four cycles.
    reset_cycle();
    we0 = 4'b0; we1 = 4'b0;
    {req0, req1} = 2'b11;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) {req0, req1} = 2'b00;
      cycle();
      if (i < 4)
        chk($sformatf("rr_gnt%0d", i), 32'(gh[0]),
            (i % 2) ? 32'b10 : 32'b01);
      if (i >= 2)
        chk($sformatf("rr_rv%0d", i), 32'(rvh[0]),
            (i % 2) ? 32'b10 : 32'b01);
    end

    // Fixed priority: port 0 wins until it drops.
    reset_cycle();
    {req0, req1} = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) req0 = 1'b0;
      cycle();
      chk($sformatf("fp_gnt%0d", i), 32'(gh[1]),
          (i < 3) ? 32'b01 : 32'b10);
    end
    req1 = 1'b0;
    cycle();
    cycle();

    // Reset during the access cycle of a full-word write.
    reset_cycle();
    req0 = 1'b1; addr0 = 32'h4;
    wdata0 = 32'hCAFEF00D; we0 = 4'b1111;
    cycle();
    req0 = 1'b0;
    reset = 1'b1;
    cycle();
    chk("mid_dwe", 32'(deh[0]), 0);
    reset = 1'b0;
    cycle();
    chk("mid_rv_a", 32'(rvh[0]), 0);
    cycle();
    chk("mid_rv_b", 32'(rvh[0]), 0);
    chk("mid_mem", mem[0][1], init_val(0, 1));

    // Idle for ten cycles.
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (gh[0] != 0 || rvh[0] != 0 || deh[0] != 0) busy++;
    end
    chk("idle_quiet", busy, 0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 49) == 0);
      req0   = ($urandom_range(0, 3) != 0);
      req1   = ($urandom_range(0, 2) != 0);
      addr0  = $urandom;
      addr1  = $urandom;
      wdata0 = $urandom;
      wdata1 = $urandom;
      we0    = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom);
      we1    = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom);
      cycle();
    end
    reset = 1'b0;
    {req0, req1} = 2'b00;
    cycle();
    cycle();
    cycle();
    for (int i = 0; i < 64; i++)
      chk($sformatf("final_mem%0d", i), mem[0][i], ref_mem[0][i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
